// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, error codes,
// bus response codes and the alignment helper.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_ADDR = ST_ADDR,
        S_DATA = ST_DATA,
        S_OUT  = ST_OUT
    } fetch_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    function automatic logic is_aligned(input logic [CPU_WIDTH-1:0] pc);
        return (pc[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the PC-stage, AR/R read channel and decode-stage signals of ifu_fetch.
// The master modport is the fetch unit's view; the slave modport is its environment.
interface ifu_fetch_if #(
    parameter int CNT_W = 32
) ();
    import ifu_fetch_pkg::*;

    logic [CPU_WIDTH-1:0] i_pc;
    logic                 i_fetch_en;
    logic [CPU_WIDTH-1:0] o_araddr;
    logic                 o_arvalid;
    logic                 i_arready;
    logic [31:0]          i_rdata;
    logic [1:0]           i_rresp;
    logic                 i_rvalid;
    logic                 o_rready;
    logic [31:0]          o_inst;
    logic [CPU_WIDTH-1:0] o_inst_pc;
    logic [1:0]           o_inst_err;
    logic                 o_inst_valid;
    logic                 i_inst_ready;
    logic                 o_pc_wen;
    logic [CNT_W-1:0]     o_fetch_cnt;

    modport master (
        input  i_pc, i_fetch_en, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready,
        output o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_err,
               o_inst_valid, o_pc_wen, o_fetch_cnt
    );

    modport slave (
        output i_pc, i_fetch_en, i_arready, i_rdata, i_rresp, i_rvalid, i_inst_ready,
        input  o_araddr, o_arvalid, o_rready, o_inst, o_inst_pc, o_inst_err,
               o_inst_valid, o_pc_wen, o_fetch_cnt
    );

endinterface

// File: rtl/stl_reg.sv
// Generic enabled register with synchronous active-high reset to a parameterised value.
module stl_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch master: samples the PC, performs one AR/R read and presents the
// instruction, its PC and an error code to decode over a valid/ready handshake.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000,
    parameter int                   CNT_W    = 32
) (
    input logic         i_clk,
    input logic         i_rst,
    ifu_fetch_if.master bus
);

    fetch_state_e         state_reg;
    logic                 aligned;
    logic                 pc_en;
    logic                 inst_en;
    logic                 handshake;
    logic [CPU_WIDTH-1:0] pc_q;
    logic [31:0]          inst_next;
    logic [31:0]          inst_q;
    logic [1:0]           err_next;
    logic [1:0]           err_q;
    logic [CNT_W-1:0]     cnt_next;
    logic [CNT_W-1:0]     cnt_q;

    assign aligned   = is_aligned(bus.i_pc);
    assign pc_en     = (state_reg == S_IDLE) && bus.i_fetch_en;
    assign handshake = (state_reg == S_OUT) && bus.i_inst_ready;
    // A misaligned PC produces its result directly from IDLE, without touching the bus.
    assign inst_en   = (pc_en && !aligned) || ((state_reg == S_DATA) && bus.i_rvalid);
    assign cnt_next  = cnt_q + CNT_W'(1);

    always_comb begin
        inst_next = '0;
        err_next  = ERR_MISALIGN;
        if (state_reg == S_DATA) begin
            if (bus.i_rresp == RRESP_OKAY) begin
                inst_next = bus.i_rdata;
                err_next  = ERR_NONE;
            end else begin
                err_next  = ERR_BUS;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (bus.i_fetch_en) state_reg <= aligned ? S_ADDR : S_OUT;
                S_ADDR: if (bus.i_arready)  state_reg <= S_DATA;
                S_DATA: if (bus.i_rvalid)   state_reg <= S_OUT;
                S_OUT:  if (bus.i_inst_ready) state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    stl_reg #(.W(CPU_WIDTH), .RST_VAL(RESET_PC)) u_pc_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(pc_en), .i_d(bus.i_pc), .o_q(pc_q)
    );

    stl_reg #(.W(32), .RST_VAL(32'h0)) u_inst_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(inst_en), .i_d(inst_next), .o_q(inst_q)
    );

    stl_reg #(.W(2), .RST_VAL(ERR_NONE)) u_err_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(inst_en), .i_d(err_next), .o_q(err_q)
    );

    stl_reg #(.W(CNT_W), .RST_VAL('0)) u_cnt_reg (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(handshake), .i_d(cnt_next), .o_q(cnt_q)
    );

    assign bus.o_araddr     = pc_q;
    assign bus.o_inst_pc    = pc_q;
    assign bus.o_inst       = inst_q;
    assign bus.o_inst_err   = err_q;
    assign bus.o_fetch_cnt  = cnt_q;
    assign bus.o_arvalid    = (state_reg == S_ADDR);
    assign bus.o_rready     = (state_reg == S_DATA);
    assign bus.o_inst_valid = (state_reg == S_OUT);
    assign bus.o_pc_wen     = handshake;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: each issued fetch pushes its expected result,
// a negedge monitor compares whenever the DUT presents bus or decode activity.
module tb_ifu_fetch;

    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  err;
        int          lat;
        int          ar_n;
        int          r_n;
        int          issue;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    exp_t       exp_q[$];
    logic [3:0] exp_cnt = '0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ar_cycles = 0;
    int         r_cycles = 0;
    logic       prev_valid = 1'b0;
    logic       cnt_chk = 1'b0;
    logic       hs;

    ifu_fetch_if #(.CNT_W(CNT_W)) bus ();

    ifu_fetch #(.RESET_PC(32'h8000_0000), .CNT_W(CNT_W)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            ar_cycles  = 0;
            r_cycles   = 0;
            cnt_chk    = 1'b0;
        end else begin
            hs = bus.o_inst_valid && bus.i_inst_ready;
            check("pc_wen", 32'(bus.o_pc_wen), 32'(hs));
            if (cnt_chk) begin
                check("fetch_cnt", 32'(bus.o_fetch_cnt), 32'(exp_cnt));
                cnt_chk = 1'b0;
            end
            if (bus.o_arvalid) ar_cycles++;
            if (bus.o_rready)  r_cycles++;
            if ((bus.o_arvalid || bus.o_rready || bus.o_inst_valid) && exp_q.size() == 0) begin
                check("unexpected_activity", 32'(1), 32'(0));
            end else if (exp_q.size() != 0) begin
                if (bus.o_arvalid) check("araddr", bus.o_araddr, exp_q[0].pc);
                if (bus.o_inst_valid) begin
                    if (!prev_valid)
                        check("latency", 32'(cyc - exp_q[0].issue), 32'(exp_q[0].lat));
                    check("inst", bus.o_inst, exp_q[0].inst);
                    check("inst_pc", bus.o_inst_pc, exp_q[0].pc);
                    check("inst_err", 32'(bus.o_inst_err), 32'(exp_q[0].err));
                    if (hs) begin
                        check("ar_cycles", 32'(ar_cycles), 32'(exp_q[0].ar_n));
                        check("r_cycles", 32'(r_cycles), 32'(exp_q[0].r_n));
                        void'(exp_q.pop_front());
                        exp_cnt   = exp_cnt + 4'd1;
                        cnt_chk   = 1'b1;
                        ar_cycles = 0;
                        r_cycles  = 0;
                    end
                end
            end
            prev_valid = bus.o_inst_valid && !hs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] rdata,
                            input logic [1:0] rresp, input int ar_dly, input int r_dly,
                            input int rdy_dly);
        exp_t e;
        logic mis;
        mis     = (pc[1:0] != 2'b00);
        e.pc    = pc;
        e.err   = mis ? 2'b01 : ((rresp != 2'b00) ? 2'b10 : 2'b00);
        e.inst  = (e.err != 2'b00) ? 32'h0 : rdata;
        e.lat   = mis ? 1 : 3 + ar_dly + r_dly;
        e.ar_n  = mis ? 0 : ar_dly + 1;
        e.r_n   = mis ? 0 : r_dly + 1;
        e.issue = cyc;
        exp_q.push_back(e);
        bus.i_pc       = pc;
        bus.i_fetch_en = 1'b1;
        tick();
        bus.i_fetch_en = 1'b0;
        bus.i_pc       = 32'h1234_5670;
        if (!mis) begin
            repeat (ar_dly) tick();
            bus.i_arready = 1'b1;
            tick();
            bus.i_arready = 1'b0;
            bus.i_rdata   = 32'hBAD0_BAD0;
            repeat (r_dly) tick();
            bus.i_rvalid = 1'b1;
            bus.i_rdata  = rdata;
            bus.i_rresp  = rresp;
            tick();
            bus.i_rvalid = 1'b0;
            bus.i_rdata  = 32'hDEAD_BEEF;
            bus.i_rresp  = 2'b00;
        end
        repeat (rdy_dly) tick();
        bus.i_inst_ready = 1'b1;
        tick();
        bus.i_inst_ready = 1'b0;
        $display("fetch pc=%h rdata=%h rresp=%0d ar_dly=%0d r_dly=%0d rdy_dly=%0d done",
                 pc, rdata, rresp, ar_dly, r_dly, rdy_dly);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arvalid"}, 32'(bus.o_arvalid), 32'(0));
        check({tag, "_rready"}, 32'(bus.o_rready), 32'(0));
        check({tag, "_inst_valid"}, 32'(bus.o_inst_valid), 32'(0));
        check({tag, "_pc_wen"}, 32'(bus.o_pc_wen), 32'(0));
        check({tag, "_inst"}, bus.o_inst, 32'h0);
        check({tag, "_inst_pc"}, bus.o_inst_pc, 32'h8000_0000);
        check({tag, "_araddr"}, bus.o_araddr, 32'h8000_0000);
        check({tag, "_inst_err"}, 32'(bus.o_inst_err), 32'(0));
        check({tag, "_fetch_cnt"}, 32'(bus.o_fetch_cnt), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        bus.i_pc = 32'h0; bus.i_fetch_en = 1'b0; bus.i_arready = 1'b0;
        bus.i_rdata = 32'h0; bus.i_rresp = 2'b00; bus.i_rvalid = 1'b0;
        bus.i_inst_ready = 1'b0;
        repeat (3) tick();
        check_reset_values("reset");
        $display("reset check done");
        rst = 1'b0;
        tick();

        do_fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0);

        // Bus handshakes while idle must be ignored.
        bus.i_arready = 1'b1; bus.i_rvalid = 1'b1; bus.i_rdata = 32'h5555_5555;
        tick(); tick();
        bus.i_arready = 1'b0; bus.i_rvalid = 1'b0;
        check("idle_inst_valid", 32'(bus.o_inst_valid), 32'(0));
        check("idle_inst", bus.o_inst, 32'h0000_0413);
        $display("idle noise check done");

        do_fetch(32'h8000_0010, 32'h1234_5678, 2'b00, 3, 2, 4);
        do_fetch(32'h8000_0002, 32'h0000_AAAA, 2'b00, 0, 0, 2);
        do_fetch(32'h8000_0020, 32'hFFFF_FFFF, 2'b10, 1, 0, 1);

        // Reset while waiting for read data.
        begin
            exp_t e;
            e.pc = 32'h8000_0080; e.inst = 32'h0; e.err = 2'b00;
            e.lat = 0; e.ar_n = 0; e.r_n = 0; e.issue = cyc;
            exp_q.push_back(e);
            bus.i_pc = 32'h8000_0080; bus.i_fetch_en = 1'b1;
            tick();
            bus.i_fetch_en = 1'b0; bus.i_arready = 1'b1;
            tick();
            bus.i_arready = 1'b0;
            tick();
            check("mid_data_rready", 32'(bus.o_rready), 32'(1));
            rst = 1'b1;
            tick();
            check_reset_values("midrst");
            exp_q.delete();
            exp_cnt = '0;
            rst = 1'b0;
            $display("reset during DATA done");
        end

        do_fetch(32'h8000_0040, 32'h0010_0093, 2'b00, 0, 1, 0);

        // Enough back-to-back fetches to carry the counter through 15 -> 0.
        for (int i = 0; i < 17; i++) begin
            do_fetch(32'h0000_0100 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 2'b00,
                     i % 2, 0, i % 3);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            tick();
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'(0));
        tick(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
